circuito_exp5: RTL and testbench
================================

Name: circuito_exp5

Overview:
- Top-level "memory sequence" game core: the player repeats a fixed 16-entry sequence of one-hot 4-bit plays on `chaves`. Round N requires entering plays 0..N-1 in order.
- A 5 s no-input timeout ends the game; so does a wrong play.
- Contains control FSM, datapath (address/limit counters, play register, edge detector, timeout counter, sequence ROM) and 7-segment debug outputs.

Parameters:
- TIMEOUT_CYCLES, 5000, cycles in wait-for-play state before timeout (5 s at 1 kHz).
- N_JOGADAS, 16, sequence length; the last round index is N_JOGADAS-1.

Ports:
- clock  in  1  system clock (1 kHz nominal)
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart request, level-sampled
- chaves  in  4  player buttons, one-hot play
- pronto  out  1  game finished (any end state)
- acertou  out  1  finished with all 16 rounds correct
- errou  out  1  finished by wrong play or timeout
- leds  out  4  equals chaves (combinational echo)
- db_igual  out  1  play register == ROM[endereco]
- db_tem_jogada  out  1  |chaves
- db_endmenorquelimite  out  1  endereco < limite
- db_clock  out  1  equals clock
- db_contagem  out  7  7-seg of endereco
- db_memoria  out  7  7-seg of ROM[endereco]
- db_jogadafeita  out  7  7-seg of play register
- db_limite  out  7  7-seg of limite
- db_estado  out  7  7-seg of state code
- db_timeout  out  7  7-seg of timeout flag (0/1)

Behaviour:
- 7-seg encoding: active-low, bit order {g,f,e,d,c,b,a}, hex digits 0-F.
- ROM contents, addresses 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex).
- Reset (async, `reset` = 0): state INICIAL; endereco, limite, play register, timeout counter and timeout flag cleared. pronto, acertou and errou are 0.
- Play pulse: a registered rising-edge detector on |chaves produces a 1-cycle pulse. A play held for many cycles counts once.
- State codes and transitions:
  - INICIAL (0): if iniciar, go to PREPARA.
  - PREPARA (1): clear endereco, limite, play register, flags; go to ESPERA.
  - ESPERA (3): timeout counter increments each cycle.
    - Play pulse: load chaves into the play register; go to REGISTRA.
    - Counter reaches TIMEOUT_CYCLES-1: go to FIM_TIMEOUT.
    - The counter clears whenever the state is not ESPERA.
  - REGISTRA (4): go to COMPARA.
  - COMPARA (5):
    - Not igual: go to FIM_ERRO.
    - Igual and endereco < limite: go to PROX_JOGADA.
    - Igual, endereco == limite, limite < 15: go to PROX_RODADA.
    - Igual, endereco == limite == 15: go to FIM_ACERTO.
  - PROX_JOGADA (6): endereco+1; go to ESPERA.
  - PROX_RODADA (7): limite+1, endereco cleared; go to ESPERA.
  - FIM_ACERTO (A): pronto=1, acertou=1.
  - FIM_ERRO (E): pronto=1, errou=1.
  - FIM_TIMEOUT (D): pronto=1, errou=1, timeout flag=1.
- End states are held until iniciar, which goes to PREPARA (restart from round 1).
- Outputs pronto, acertou and errou are Moore, decoded from the state.
- iniciar is ignored outside INICIAL and the end states.
- Play pulses outside ESPERA are discarded.
- Multi-bit or zero-edge patterns are registered as-is and compare unequal unless they match the ROM entry.
- Counters are 4 bits wide and never wrap in normal flow.

Decomposition:
- Package: state enum with the codes above, TIMEOUT_CYCLES, ROM contents as a constant array.
- Natural sub-module: hexa7seg (4-bit to 7-seg, active-low), instantiated six times.
- Datapath and FSM may stay in one module.

Test Plan:
- Reset held 10 cycles, then released → state 0; pronto, acertou, errou = 0; db_estado shows "0".
- iniciar 1 cycle, then rounds 1-3 played correctly (1 / 1,2 / 1,2,4; each held 5 cycles, 5-cycle gaps) → limite=3 after round 3; errou=0; pronto=0.
- Round 4 entered as 1,2,2 → after the third play, state E: errou=1, pronto=1, acertou=0; db_jogadafeita shows "2", db_memoria shows "4".
- From FIM_ERRO, iniciar held 5 cycles → PREPARA then ESPERA; limite=0, endereco=0, errou=0.
- Start, then no play for 5000 cycles → state D: errou=1, pronto=1; db_timeout shows "1".
- Full 16 rounds played correctly → state A: acertou=1, pronto=1, limite=15.

Source files
------------

// File: rtl/circuito_exp5_pkg.sv
// Shared types and constants for the memory-sequence game core.
// Holds the state codes, default sizing and the fixed play sequence.
package circuito_exp5_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROX_JOGADA = 4'h6,
        PROX_RODADA = 4'h7,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    localparam int TIMEOUT_CYCLES_DFLT = 5000;
    localparam int N_JOGADAS_DFLT      = 16;

    localparam logic [3:0] SEQ_ROM [16] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
    };

    function automatic logic [3:0] rom_read(input logic [3:0] addr);
        return SEQ_ROM[addr];
    endfunction

endpackage

// File: rtl/circuito_exp5_hexa7seg.sv
// Hex digit to 7-segment decoder, active-low, bit order {g,f,e,d,c,b,a}.
module hexa7seg (
    input  logic [3:0] valor,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (valor)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/circuito_exp5.sv
// Memory-sequence game core: control FSM, datapath and 7-segment debug taps.
//
// state        | meaning
// INICIAL (0)  | idle after reset, waits for iniciar
// PREPARA (1)  | clears counters, play register and result flags
// ESPERA  (3)  | waits for a play pulse or the no-input timeout
// REGISTRA(4)  | play register settles
// COMPARA (5)  | checks play against sequence, picks next step
// PROX_JOGADA(6)| advance to next play within the round
// PROX_RODADA(7)| extend round by one, restart address
// FIM_ACERTO(A)| all rounds completed
// FIM_TIMEOUT(D)| no play within the time window
// FIM_ERRO (E) | wrong play
module circuito_exp5
    import circuito_exp5_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
    parameter int N_JOGADAS      = N_JOGADAS_DFLT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic       db_tem_jogada,
    output logic       db_endmenorquelimite,
    output logic       db_clock,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_limite,
    output logic [6:0] db_estado,
    output logic [6:0] db_timeout
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] ULTIMA   = 4'(N_JOGADAS - 1);

    estado_t       estado;
    logic [3:0]    endereco, limite, jogada;
    logic [TW-1:0] tmr;
    logic          tem_prev, timeout_flag;
    logic          tem_jogada, pulso, igual, tmr_tc;
    logic [3:0]    memoria;

    assign tem_jogada = |chaves;
    assign pulso      = tem_jogada & ~tem_prev;
    assign memoria    = rom_read(endereco);
    assign igual      = (jogada == memoria);
    assign tmr_tc     = (tmr == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= INICIAL;
            endereco     <= '0;
            limite       <= '0;
            jogada       <= '0;
            tmr          <= TMR_LOAD;
            tem_prev     <= 1'b0;
            timeout_flag <= 1'b0;
            pronto       <= 1'b0;
            acertou      <= 1'b0;
            errou        <= 1'b0;
        end else begin
            tem_prev <= tem_jogada;
            // Down-counter holds its load value outside ESPERA, so each wait gets a full window.
            if (estado != ESPERA)
                tmr <= TMR_LOAD;
            else if (!tmr_tc)
                tmr <= tmr - TW'(1);

            case (estado)
                INICIAL: if (iniciar) estado <= PREPARA;
                PREPARA: begin
                    endereco     <= '0;
                    limite       <= '0;
                    jogada       <= '0;
                    timeout_flag <= 1'b0;
                    pronto       <= 1'b0;
                    acertou      <= 1'b0;
                    errou        <= 1'b0;
                    estado       <= ESPERA;
                end
                ESPERA: begin
                    if (pulso) begin
                        jogada <= chaves;
                        estado <= REGISTRA;
                    end else if (tmr_tc) begin
                        timeout_flag <= 1'b1;
                        pronto       <= 1'b1;
                        errou        <= 1'b1;
                        estado       <= FIM_TIMEOUT;
                    end
                end
                REGISTRA: estado <= COMPARA;
                COMPARA: begin
                    if (!igual) begin
                        pronto <= 1'b1;
                        errou  <= 1'b1;
                        estado <= FIM_ERRO;
                    end else if (endereco < limite) begin
                        estado <= PROX_JOGADA;
                    end else if (limite < ULTIMA) begin
                        estado <= PROX_RODADA;
                    end else begin
                        pronto  <= 1'b1;
                        acertou <= 1'b1;
                        estado  <= FIM_ACERTO;
                    end
                end
                PROX_JOGADA: begin
                    endereco <= endereco + 4'd1;
                    estado   <= ESPERA;
                end
                PROX_RODADA: begin
                    limite   <= limite + 4'd1;
                    endereco <= '0;
                    estado   <= ESPERA;
                end
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) estado <= PREPARA;
                default: estado <= INICIAL;
            endcase
        end
    end

    assign leds                 = chaves;
    assign db_igual             = igual;
    assign db_tem_jogada        = tem_jogada;
    assign db_endmenorquelimite = (endereco < limite);
    assign db_clock             = clock;

    hexa7seg u_seg_contagem (.valor(endereco),               .seg(db_contagem));
    hexa7seg u_seg_memoria  (.valor(memoria),                .seg(db_memoria));
    hexa7seg u_seg_jogada   (.valor(jogada),                 .seg(db_jogadafeita));
    hexa7seg u_seg_limite   (.valor(limite),                 .seg(db_limite));
    hexa7seg u_seg_estado   (.valor(4'(estado)),             .seg(db_estado));
    hexa7seg u_seg_timeout  (.valor({3'b000, timeout_flag}), .seg(db_timeout));

endmodule

// File: tb/tb_circuito_exp5.sv
// Directed bench for circuito_exp5 with a game-level reference model checked every cycle.
module tb_circuito_exp5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'h0;
    logic       pronto, acertou, errou, db_igual, db_tem_jogada;
    logic       db_endmenorquelimite, db_clock;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_limite, db_estado, db_timeout;

    circuito_exp5 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .pronto(pronto), .acertou(acertou), .errou(errou), .leds(leds),
        .db_igual(db_igual), .db_tem_jogada(db_tem_jogada),
        .db_endmenorquelimite(db_endmenorquelimite), .db_clock(db_clock),
        .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_jogadafeita(db_jogadafeita), .db_limite(db_limite),
        .db_estado(db_estado), .db_timeout(db_timeout)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] rom_m [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                               4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    // Game status: 0 idle, 1 playing, 2 won, 3 wrong play, 4 timed out.
    int         m_status = 0;
    logic [3:0] m_end = 4'h0, m_lim = 4'h0, m_last = 4'h0;
    bit         chk_en = 1'b0;
    bit         live_en = 1'b0;

    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic logic [3:0] state_code(input int st);
        case (st)
            1:       return 4'h3;
            2:       return 4'hA;
            3:       return 4'hE;
            4:       return 4'hD;
            default: return 4'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (live_en) begin
            check("leds", 32'(leds), 32'(chaves));
            check("db_tem_jogada", 32'(db_tem_jogada), 32'(|chaves));
            check("db_clock", 32'(db_clock), 32'(clock));
        end
        if (chk_en) begin
            check("pronto", 32'(pronto), 32'(m_status >= 2));
            check("acertou", 32'(acertou), 32'(m_status == 2));
            check("errou", 32'(errou), 32'(m_status == 3 || m_status == 4));
            check("db_estado", 32'(db_estado), 32'(seg(state_code(m_status))));
            check("db_limite", 32'(db_limite), 32'(seg(m_lim)));
            check("db_contagem", 32'(db_contagem), 32'(seg(m_end)));
            check("db_memoria", 32'(db_memoria), 32'(seg(rom_m[m_end])));
            check("db_jogadafeita", 32'(db_jogadafeita), 32'(seg(m_last)));
            check("db_endmenorquelimite", 32'(db_endmenorquelimite), 32'(m_end < m_lim));
            check("db_igual", 32'(db_igual), 32'(m_last == rom_m[m_end]));
            check("db_timeout", 32'(db_timeout), 32'(seg({3'b000, m_status == 4})));
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic model_play(input logic [3:0] p);
        if (m_status != 1) return;
        m_last = p;
        if (p != rom_m[m_end])  m_status = 3;
        else if (m_end < m_lim) m_end = m_end + 4'd1;
        else if (m_lim < 4'd15) begin
            m_lim = m_lim + 4'd1;
            m_end = 4'h0;
        end else                m_status = 2;
    endtask

    task automatic start_game(input int hold);
        chk_en  = 1'b0;
        iniciar = 1'b1;
        repeat (hold) tick();
        iniciar = 1'b0;
        tick();
        m_status = 1;
        m_end = 4'h0;
        m_lim = 4'h0;
        m_last = 4'h0;
        chk_en = 1'b1;
    endtask

    task automatic play(input logic [3:0] p);
        chk_en = 1'b0;
        chaves = p;
        repeat (5) tick();
        chaves = 4'h0;
        model_play(p);
        chk_en = 1'b1;
        repeat (5) tick();
    endtask

    task automatic play_round(input int r);
        for (int i = 0; i < r; i++) play(rom_m[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        repeat (10) tick();
        check("reset_pronto", 32'(pronto), 32'h0);
        check("reset_estado", 32'(db_estado), 32'h40);
        reset = 1'b1;
        live_en = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();
        check("idle_estado", 32'(db_estado), 32'h40);

        start_game(1);
        play_round(1);
        chk_en = 1'b0;
        chk_en = 1'b1;
        iniciar = 1'b1;
        repeat (3) tick();
        iniciar = 1'b0;
        play_round(2);
        play_round(3);
        check("r3_limite", 32'(db_limite), 32'h30);
        check("r3_errou", 32'(errou), 32'h0);
        check("r3_pronto", 32'(pronto), 32'h0);

        play(4'h1);
        play(4'h2);
        play(4'h2);
        check("err_estado", 32'(db_estado), 32'h06);
        check("err_errou", 32'(errou), 32'h1);
        check("err_acertou", 32'(acertou), 32'h0);
        check("err_jogada", 32'(db_jogadafeita), 32'h24);
        check("err_memoria", 32'(db_memoria), 32'h19);

        start_game(5);
        check("restart_limite", 32'(db_limite), 32'h40);
        check("restart_contagem", 32'(db_contagem), 32'h40);
        check("restart_errou", 32'(errou), 32'h0);
        play(4'h3);
        check("multibit_estado", 32'(db_estado), 32'h06);
        check("multibit_jogada", 32'(db_jogadafeita), 32'h30);

        start_game(1);
        chk_en = 1'b0;
        repeat (4999) tick();
        check("pre_timeout_estado", 32'(db_estado), 32'h30);
        tick();
        check("timeout_estado", 32'(db_estado), 32'h21);
        check("timeout_flag", 32'(db_timeout), 32'h79);
        check("timeout_errou", 32'(errou), 32'h1);
        m_status = 4;
        chk_en = 1'b1;
        repeat (3) tick();

        start_game(5);
        for (int r = 1; r <= 16; r++) play_round(r);
        check("win_estado", 32'(db_estado), 32'h08);
        check("win_limite", 32'(db_limite), 32'h0E);
        check("win_acertou", 32'(acertou), 32'h1);
        check("win_pronto", 32'(pronto), 32'h1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
